// File: rtl/rx_agc_loop.sv
// rx_agc_loop: settle/decide receive AGC driving a PGA gain code into a level window.
// Optional AGC_FAST_ATTACK_EN: overload also checked every SETTLE cycle.
module rx_agc_loop #(
  parameter logic [6:0] SR_BASE  = 7'd100,
  parameter logic [4:0] MAX_GAIN = 5'd20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic [15:0] rssi,
  input  logic [15:0] over_count,
  output logic [4:0]  gain,
  output logic        gain_strobe,
  output logic        locked
);
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;
  state_t state_q, state_d;
  logic [15:0] thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d, dwell_q, dwell_d, cnt_q, cnt_d;
  logic [4:0] manual_gain_q, manual_gain_d, gain_q, gain_d, man, dec2, dec1, inc1, step;
  logic agc_on_q, agc_on_d, gain_strobe_q, gain_strobe_d, locked_q, locked_d;
  logic wr_a, wr_b, run;
  logic unused_bits;
  assign unused_bits = ^serial_data[30:21];
  always_comb begin
    wr_a = serial_strobe && serial_addr == SR_BASE;
    wr_b = serial_strobe && serial_addr == SR_BASE + 7'd1;
    thr_hi_d = wr_a ? serial_data[31:16] : thr_hi_q;
    thr_lo_d = wr_a ? serial_data[15:0] : thr_lo_q;
    agc_on_d = wr_b ? serial_data[31] : agc_on_q;
    manual_gain_d = wr_b ? serial_data[20:16] : manual_gain_q;
    dwell_d = wr_b ? serial_data[15:0] : dwell_q;
    run = agc_on_q && enable;
    man = manual_gain_q > MAX_GAIN ? MAX_GAIN : manual_gain_q;
    dec2 = gain_q < 5'd2 ? 5'd0 : gain_q - 5'd2;
    dec1 = gain_q == 5'd0 ? 5'd0 : gain_q - 5'd1;
    inc1 = gain_q >= MAX_GAIN ? MAX_GAIN : gain_q + 5'd1;
    // decrement branches come first, so an inverted window still backs gain off
    step = over_count != 16'd0 ? dec2 : rssi > thr_hi_q ? dec1 : rssi < thr_lo_q ? inc1 : gain_q;
    state_d = state_q;
    cnt_d = cnt_q;
    gain_d = gain_q;
    locked_d = locked_q;
    if (!run && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE: begin
          gain_d = man;
          locked_d = 1'b0;
          if (run) begin
            state_d = SETTLE;
            cnt_d = dwell_q;
          end
        end
        SETTLE: begin
`ifdef AGC_FAST_ATTACK_EN
          if (over_count != 16'd0) begin
            gain_d = dec2;
            locked_d = 1'b0;
            cnt_d = dwell_q;
          end else if (cnt_q == 16'd0) state_d = DECIDE;
          else cnt_d = cnt_q - 16'd1;
`else
          if (cnt_q == 16'd0) state_d = DECIDE;
          else cnt_d = cnt_q - 16'd1;
`endif
        end
        DECIDE: begin
          gain_d = step;
          locked_d = step == gain_q;
          state_d = SETTLE;
          cnt_d = dwell_q;
        end
        default: state_d = IDLE;
      endcase
    gain_strobe_d = gain_d != gain_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 16'd0;
      thr_hi_q <= 16'hFFFF;
      thr_lo_q <= 16'd0;
      agc_on_q <= 1'b0;
      manual_gain_q <= 5'd0;
      dwell_q <= 16'd0;
      gain_q <= 5'd0;
      gain_strobe_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      thr_hi_q <= thr_hi_d;
      thr_lo_q <= thr_lo_d;
      agc_on_q <= agc_on_d;
      manual_gain_q <= manual_gain_d;
      dwell_q <= dwell_d;
      gain_q <= gain_d;
      gain_strobe_q <= gain_strobe_d;
      locked_q <= locked_d;
    end
  end
  assign gain = gain_q;
  assign gain_strobe = gain_strobe_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_rx_agc_loop.sv
// tb_rx_agc_loop: directed test-plan scenarios plus random traffic against a time-based AGC model.
module tb_rx_agc_loop;
  localparam int MAXG = 20;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, serial_strobe = 1'b0;
  logic [6:0] serial_addr = 7'd0;
  logic [31:0] serial_data = 32'd0;
  logic [15:0] rssi = 16'd0, over_count = 16'd0;
  logic [4:0] gain;
  logic gain_strobe, locked;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_gain, m_locked, m_strobe, m_run, next_dec;
  int m_hi, m_lo, m_agc, m_man, m_dwell;
  rx_agc_loop dut (
    .clock(clock), .reset(reset), .enable(enable), .serial_addr(serial_addr),
    .serial_data(serial_data), .serial_strobe(serial_strobe), .rssi(rssi),
    .over_count(over_count), .gain(gain), .gain_strobe(gain_strobe), .locked(locked)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v < 0 ? 0 : v > MAXG ? MAXG : v;
  endfunction
  task automatic model_edge();
    int g0 = m_gain;
    int t;
    if (reset) begin
      m_gain = 0; m_locked = 0; m_strobe = 0; m_run = 0; next_dec = 0;
      m_hi = 16'hFFFF; m_lo = 0; m_agc = 0; m_man = 0; m_dwell = 0;
      return;
    end
    if (m_run == 0) begin
      m_gain = sat(m_man);
      m_locked = 0;
      if (m_agc != 0 && enable) begin
        m_run = 1;
        next_dec = cyc + m_dwell + 2;
      end
    end else if (!(m_agc != 0 && enable)) m_run = 0;
    else if (cyc == next_dec) begin
      t = over_count != 0 ? sat(m_gain - 2) : int'(rssi) > m_hi ? sat(m_gain - 1) :
          int'(rssi) < m_lo ? sat(m_gain + 1) : m_gain;
      m_locked = t == m_gain;
      m_gain = t;
      next_dec = cyc + m_dwell + 2;
    end
`ifdef AGC_FAST_ATTACK_EN
    else if (over_count != 0) begin
      m_gain = sat(m_gain - 2);
      m_locked = 0;
      next_dec = cyc + m_dwell + 1;
    end
`endif
    if (serial_strobe && serial_addr == 7'd100) begin
      m_hi = serial_data[31:16]; m_lo = serial_data[15:0];
    end
    if (serial_strobe && serial_addr == 7'd101) begin
      m_agc = serial_data[31]; m_man = serial_data[20:16]; m_dwell = serial_data[15:0];
    end
    m_strobe = m_gain != g0;
  endtask
  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    chk("gain", gain, m_gain);
    chk("strobe", gain_strobe, m_strobe);
    chk("locked", locked, m_locked);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_addr = a; serial_data = d; serial_strobe = 1'b1;
    step();
    serial_strobe = 1'b0;
  endtask
  initial begin
    int strobes;
    run(2);
    reset = 1'b0;
    step();
    chk("rst_gain", gain, 0);
    chk("rst_locked", locked, 0);
    wr(7'd101, {1'b0, 10'd0, 5'd25, 16'd0});
    step();
    chk("man_clamp", gain, 20);
    chk("man_strobe", gain_strobe, 1);
    step();
    chk("man_strobe_off", gain_strobe, 0);
    wr(7'd100, {16'd1000, 16'd500});
    enable = 1'b1; rssi = 16'd200;
    wr(7'd101, {1'b1, 10'd0, 5'd10, 16'd3});
    run(2);
    chk("start_gain", gain, 10);
    run(5);
    chk("first_step", gain, 11);
    run(60);
    chk("sat_gain", gain, 20);
    chk("sat_locked", locked, 1);
    strobes = 0;
    rssi = 16'd700;
    for (int i = 0; i < 20; i++) begin
      step();
      strobes += int'(gain_strobe);
    end
    chk("window_gain", gain, 20);
    chk("window_strobes", strobes, 0);
    rssi = 16'd2000; over_count = 16'd3;
    run(60);
    chk("floor_gain", gain, 0);
    chk("floor_locked", locked, 1);
    over_count = 16'd0; rssi = 16'd200;
    run(13);
    enable = 1'b0;
    run(3);
    chk("dis_gain", gain, 10);
    enable = 1'b1;
    run(4);
    reset = 1'b1;
    step();
    chk("midrst_gain", gain, 0);
    chk("midrst_locked", locked, 0);
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      int r = int'($urandom_range(0, 99));
      serial_strobe = 1'b0;
      if (r < 4) begin
        serial_strobe = 1'b1; serial_addr = 7'd100;
        serial_data = {16'($urandom_range(0, 900)), 16'($urandom_range(0, 900))};
      end else if (r < 8) begin
        serial_strobe = 1'b1; serial_addr = 7'd101;
        serial_data = {1'($urandom_range(0, 9) != 0), 10'($urandom), 5'($urandom), 16'($urandom_range(0, 6))};
      end else if (r < 10) begin
        serial_strobe = 1'b1; serial_addr = 7'($urandom_range(0, 99)); serial_data = $urandom;
      end
      enable = $urandom_range(0, 40) != 0;
      reset = $urandom_range(0, 499) == 0;
      rssi = 16'($urandom_range(0, 1023));
      over_count = $urandom_range(0, 9) == 0 ? 16'($urandom_range(1, 3)) : 16'd0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
